mc_ctrl: RTL and testbench

- Main control FSM of the multi-cycle MIPS core.
- Decodes `op`/`funct` from the instruction register and sequences the fetch/decode/execute/memory/writeback states.
- Per state, drives every datapath enable and mux select, including `ext_op` to the immediate extender.
- Sits upstream of the extender, ALU, register file, data memory and PC.

---
 rtl/mc_pkg.sv | 77 +++++++
 rtl/mc_decode.sv | 33 +++
 rtl/mc_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: states, opcodes,
// funct codes, extender/ALU modes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch = 4'd0,
    StDcd   = 4'd1,
    StMa    = 4'd2,
    StMr    = 4'd3,
    StWbm   = 4'd4,
    StMw    = 4'd5,
    StExe   = 4'd6,
    StAwb   = 4'd7,
    StBr    = 4'd8,
    StJmp   = 4'd9
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] EXT_SHL2 = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  localparam logic       ASEL_PC = 1'b0;
  localparam logic       ASEL_RS = 1'b1;

  localparam logic [1:0] BSEL_RT  = 2'b00;
  localparam logic [1:0] BSEL_4   = 2'b01;
  localparam logic [1:0] BSEL_EXT = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_DR     = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

  localparam logic [1:0] NPC_ALU    = 2'b00;
  localparam logic [1:0] NPC_ALUOUT = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_RS     = 2'b11;

  // One-hot instruction class; all zero means an unsupported encoding.
  typedef struct packed {
    logic lw;
    logic sw;
    logic addu;
    logic subu;
    logic slt;
    logic jr;
    logic ori;
    logic lui;
    logic beq;
    logic j;
    logic jal;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/funct decoder producing the one-hot instruction class.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  always_comb begin
    cls = '0;
    unique case (op)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_SLT:  cls.slt  = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Main control FSM of the multi-cycle MIPS core.
// Optional retired-instruction counter enabled by defining CTRL_RETIRE_CNT_EN.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic             rf_wr,
  output logic             dm_wr,
  output logic [1:0]       ext_op,
  output logic             alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [1:0]       alu_op,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic [1:0]       npc_sel,
  output logic [3:0]       state_o
`ifdef CTRL_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  state_e  state_q, state_d;
  iclass_t cls;
  logic    is_arith;
  logic    pc_wr_raw, ir_wr_raw, rf_wr_raw, dm_wr_raw;

  mc_decode u_decode (
    .op    (op),
    .funct (funct),
    .cls   (cls)
  );

  assign is_arith = cls.addu | cls.subu | cls.slt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = StFetch;
    pc_wr_raw = 1'b0;
    ir_wr_raw = 1'b0;
    rf_wr_raw = 1'b0;
    dm_wr_raw = 1'b0;
    ext_op    = EXT_SIGN;
    alu_a_sel = ASEL_PC;
    alu_b_sel = BSEL_RT;
    alu_op    = ALU_ADD;
    reg_dst   = DST_RT;
    wd_sel    = WD_ALUOUT;
    npc_sel   = NPC_ALU;
    unique case (state_q)
      StFetch: begin
        ir_wr_raw = 1'b1;
        pc_wr_raw = 1'b1;
        alu_b_sel = BSEL_4;
        state_d   = StDcd;
      end
      StDcd: begin
        // Precompute the branch target into ALUOut while the class resolves.
        alu_b_sel = BSEL_EXT;
        ext_op    = EXT_SHL2;
        if (cls.lw || cls.sw) begin
          state_d = StMa;
        end else if (is_arith || cls.ori || cls.lui) begin
          state_d = StExe;
        end else if (cls.beq) begin
          state_d = StBr;
        end else if (cls.j || cls.jal || cls.jr) begin
          state_d = StJmp;
        end
      end
      StMa: begin
        alu_a_sel = ASEL_RS;
        alu_b_sel = BSEL_EXT;
        state_d   = cls.lw ? StMr : StMw;
      end
      StMr:  state_d = StWbm;
      StWbm: begin
        rf_wr_raw = 1'b1;
        wd_sel    = WD_DR;
      end
      StMw:  dm_wr_raw = 1'b1;
      StExe: begin
        alu_a_sel = ASEL_RS;
        state_d   = StAwb;
        if (cls.ori) begin
          alu_b_sel = BSEL_EXT;
          ext_op    = EXT_ZERO;
          alu_op    = ALU_OR;
        end else if (cls.lui) begin
          alu_b_sel = BSEL_EXT;
          ext_op    = EXT_LUI;
          alu_op    = ALU_OR;
        end else if (cls.subu) begin
          alu_op = ALU_SUB;
        end else if (cls.slt) begin
          alu_op = ALU_SLT;
        end
      end
      StAwb: begin
        rf_wr_raw = 1'b1;
        reg_dst   = is_arith ? DST_RD : DST_RT;
      end
      StBr: begin
        alu_a_sel = ASEL_RS;
        alu_op    = ALU_SUB;
        npc_sel   = NPC_ALUOUT;
        pc_wr_raw = zero;
      end
      StJmp: begin
        pc_wr_raw = 1'b1;
        npc_sel   = cls.jr ? NPC_RS : NPC_JUMP;
        if (cls.jal) begin
          rf_wr_raw = 1'b1;
          reg_dst   = DST_RA;
          wd_sel    = WD_PC;
        end
      end
      default: ;
    endcase
  end

  // Write enables are gated by the asynchronous reset so no partial write escapes.
  assign pc_wr   = pc_wr_raw & ~rst;
  assign ir_wr   = ir_wr_raw & ~rst;
  assign rf_wr   = rf_wr_raw & ~rst;
  assign dm_wr   = dm_wr_raw & ~rst;
  assign state_o = state_q;

`ifdef CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_q;
  logic             retire_ev;

  assign retire_ev = state_q inside {StWbm, StMw, StAwb, StBr, StJmp};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_q <= '0;
    end else if (retire_ev) begin
      retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign retire_cnt = retire_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: a per-instruction reference model pushes the
// expected per-cycle control vectors; a negedge monitor pops and compares.
module tb_mc_ctrl;
  import mc_pkg::*;

  localparam int K_LW = 0, K_SW = 1, K_ADDU = 2, K_SUBU = 3, K_SLT = 4, K_JR = 5;
  localparam int K_ORI = 6, K_LUI = 7, K_BEQ = 8, K_J = 9, K_JAL = 10, K_ILL = 11;

  typedef struct packed {
    logic [3:0]  st;
    logic        pc_wr;
    logic        ir_wr;
    logic        rf_wr;
    logic        dm_wr;
    logic [1:0]  ext;
    logic        a;
    logic [1:0]  b;
    logic [1:0]  alu;
    logic [1:0]  dst;
    logic [1:0]  wd;
    logic [1:0]  npc;
    logic [31:0] cnt;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op, funct;
  logic        zero;
  logic        pc_wr, ir_wr, rf_wr, dm_wr, alu_a_sel;
  logic [1:0]  ext_op, alu_b_sel, alu_op, reg_dst, wd_sel, npc_sel;
  logic [3:0]  state_o;
`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  mc_ctrl #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .pc_wr     (pc_wr),
    .ir_wr     (ir_wr),
    .rf_wr     (rf_wr),
    .dm_wr     (dm_wr),
    .ext_op    (ext_op),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_op    (alu_op),
    .reg_dst   (reg_dst),
    .wd_sel    (wd_sel),
    .npc_sel   (npc_sel),
    .state_o   (state_o)
`ifdef CTRL_RETIRE_CNT_EN
    ,
    .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  rec_t        exp_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [31:0] model_cnt = 0;

  function automatic rec_t sample();
    rec_t r;
    r = '{st: state_o, pc_wr: pc_wr, ir_wr: ir_wr, rf_wr: rf_wr, dm_wr: dm_wr, ext: ext_op,
          a: alu_a_sel, b: alu_b_sel, alu: alu_op, dst: reg_dst, wd: wd_sel, npc: npc_sel,
          cnt: 32'd0};
`ifdef CTRL_RETIRE_CNT_EN
    r.cnt = retire_cnt;
`endif
    return r;
  endfunction

  // Idle values for a given state: nothing enabled, sign-extend, everything else 0.
  function automatic rec_t idle(input logic [3:0] st);
    rec_t r;
    r     = '0;
    r.st  = st;
    r.ext = 2'b01;
    r.cnt = model_cnt;
    return r;
  endfunction

  // Reference model: the full cycle-by-cycle control trace of one instruction.
  task automatic push_instr(input int k, input logic z, input string nm, output int n);
    rec_t r[$];
    rec_t t;
    t = idle(StFetch); t.ir_wr = 1; t.pc_wr = 1; t.b = 2'b01; r.push_back(t);
    t = idle(StDcd);   t.b = 2'b10; t.ext = 2'b11;           r.push_back(t);
    case (k)
      K_LW, K_SW: begin
        t = idle(StMa); t.a = 1; t.b = 2'b10; r.push_back(t);
        if (k == K_LW) begin
          r.push_back(idle(StMr));
          t = idle(StWbm); t.rf_wr = 1; t.wd = 2'b01; r.push_back(t);
        end else begin
          t = idle(StMw); t.dm_wr = 1; r.push_back(t);
        end
      end
      K_ADDU, K_SUBU, K_SLT, K_ORI, K_LUI: begin
        t = idle(StExe); t.a = 1;
        case (k)
          K_SUBU:  t.alu = 2'b01;
          K_SLT:   t.alu = 2'b11;
          K_ORI:   begin t.b = 2'b10; t.ext = 2'b00; t.alu = 2'b10; end
          K_LUI:   begin t.b = 2'b10; t.ext = 2'b10; t.alu = 2'b10; end
          default: t.alu = 2'b00;
        endcase
        r.push_back(t);
        t = idle(StAwb); t.rf_wr = 1;
        t.dst = (k == K_ORI || k == K_LUI) ? 2'b00 : 2'b01;
        r.push_back(t);
      end
      K_BEQ: begin
        t = idle(StBr); t.a = 1; t.alu = 2'b01; t.npc = 2'b01; t.pc_wr = z; r.push_back(t);
      end
      K_J, K_JAL, K_JR: begin
        t = idle(StJmp); t.pc_wr = 1; t.npc = (k == K_JR) ? 2'b11 : 2'b10;
        if (k == K_JAL) begin t.rf_wr = 1; t.dst = 2'b10; t.wd = 2'b10; end
        r.push_back(t);
      end
      default: ;
    endcase
    n = r.size();
    foreach (r[i]) begin
      exp_q.push_back(r[i]);
      name_q.push_back($sformatf("%s[%0d]", nm, i));
    end
    if (k != K_ILL) model_cnt = model_cnt + 32'd1;
  endtask

  function automatic bit legal_op(input logic [5:0] o);
    return o inside {6'b000000, 6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b001111,
                     6'b000010, 6'b000011};
  endfunction

  task automatic encode(input int k, output logic [5:0] o, output logic [5:0] f);
    o = 6'($urandom);
    f = 6'($urandom);
    case (k)
      K_LW:   o = 6'b100011;
      K_SW:   o = 6'b101011;
      K_ORI:  o = 6'b001101;
      K_LUI:  o = 6'b001111;
      K_BEQ:  o = 6'b000100;
      K_J:    o = 6'b000010;
      K_JAL:  o = 6'b000011;
      K_ADDU: begin o = 6'b000000; f = 6'b100001; end
      K_SUBU: begin o = 6'b000000; f = 6'b100011; end
      K_SLT:  begin o = 6'b000000; f = 6'b101010; end
      K_JR:   begin o = 6'b000000; f = 6'b001000; end
      default: begin
        if ($urandom_range(0, 2) == 0) begin
          o = 6'b000000;
          while (f inside {6'b100001, 6'b100011, 6'b101010, 6'b001000}) f = 6'($urandom);
        end else begin
          while (legal_op(o)) o = 6'($urandom);
        end
      end
    endcase
  endtask

  // Called in a FETCH cycle shortly after the clock edge; returns in the next FETCH cycle.
  task automatic run_instr(input int k, input logic z, input logic [5:0] o, input logic [5:0] f);
    int n;
    op    = o;
    funct = f;
    zero  = z;
    push_instr(k, z, $sformatf("k%0d_op%b_fn%b_z%0d", k, o, f, z), n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_kind(input int k, input logic z);
    logic [5:0] o, f;
    encode(k, o, f);
    run_instr(k, z, o, f);
  endtask

  initial begin : monitor
    rec_t  got, exp;
    string nm;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        got = sample();
        n_vec++;
        if (rst) begin
          if (got.st !== 4'd0 || {got.pc_wr, got.ir_wr, got.rf_wr, got.dm_wr} !== 4'b0000
`ifdef CTRL_RETIRE_CNT_EN
              || got.cnt !== 32'd0
`endif
              ) begin
            n_err++;
            $display("FAIL reset: got st=%0d we=%b cnt=%0d, required st=0 we=0000 cnt=0",
                     got.st, {got.pc_wr, got.ir_wr, got.rf_wr, got.dm_wr}, got.cnt);
          end
        end else if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard_empty: got st=%0d with no expected vector", got.st);
        end else begin
          exp = exp_q.pop_front();
          nm  = name_q.pop_front();
`ifndef CTRL_RETIRE_CNT_EN
          exp.cnt = 32'd0;
`endif
          if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got st=%0d pc/ir/rf/dm=%b ext=%b a=%b b=%b alu=%b dst=%b wd=%b npc=%b cnt=%0d, required st=%0d pc/ir/rf/dm=%b ext=%b a=%b b=%b alu=%b dst=%b wd=%b npc=%b cnt=%0d",
                     nm, got.st, {got.pc_wr, got.ir_wr, got.rf_wr, got.dm_wr}, got.ext, got.a,
                     got.b, got.alu, got.dst, got.wd, got.npc, got.cnt,
                     exp.st, {exp.pc_wr, exp.ir_wr, exp.rf_wr, exp.dm_wr}, exp.ext, exp.a,
                     exp.b, exp.alu, exp.dst, exp.wd, exp.npc, exp.cnt);
          end
        end
      end
    end
  end

  initial begin : driver
    int n;
    logic z;
    rst    = 1'b1;
    op     = 6'b100011;
    funct  = 6'd0;
    zero   = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed: the instruction mix called out for this controller.
    run_kind(K_LW, 1'b0);
    run_kind(K_SW, 1'b0);
    run_instr(K_ILL, 1'b0, 6'b111111, 6'd0);
    run_kind(K_BEQ, 1'b1);
    run_kind(K_BEQ, 1'b0);
    run_kind(K_ORI, 1'b0);
    run_kind(K_LUI, 1'b0);
    run_kind(K_JAL, 1'b0);
    run_kind(K_JR, 1'b0);
    run_kind(K_J, 1'b1);
    run_kind(K_ADDU, 1'b0);
    run_kind(K_SUBU, 1'b1);
    run_kind(K_SLT, 1'b0);

    // Reset asserted mid-MR of a load: only FETCH/DCD/MA of it are ever seen.
    op    = 6'b100011;
    funct = 6'($urandom);
    push_instr(K_LW, 1'b0, "lw_aborted", n);
    repeat (2) void'(exp_q.pop_back());
    repeat (2) void'(name_q.pop_back());
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    model_cnt = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_kind(K_LW, 1'b0);

    for (int i = 0; i < 400; i++) begin
      z = 1'($urandom);
      run_kind(int'($urandom_range(0, 11)), z);
    end

    mon_en = 1'b0;
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
